// File: rtl/ir_ttd_sampler_if.sv
// Signal bundle for the IR time-to-decay sampler: channel select, sensor
// pads, emitter enables and the per-frame result bus.
// master: the sampler itself. slave: whatever drives selects and pads.
interface ir_ttd_sampler_if;
    logic [7:0]   channel_sel;
    logic [7:0]   sense_in;
    logic [7:0]   sense_oe;
    logic         ir_evenLED;
    logic         ir_oddLED;
    logic [135:0] ttd_flat;
    logic         frame_valid;

    modport master (
        input  channel_sel,
        input  sense_in,
        output sense_oe,
        output ir_evenLED,
        output ir_oddLED,
        output ttd_flat,
        output frame_valid
    );

    modport slave (
        output channel_sel,
        output sense_in,
        input  sense_oe,
        input  ir_evenLED,
        input  ir_oddLED,
        input  ttd_flat,
        input  frame_valid
    );
endinterface

// File: rtl/ir_ttd_sampler.sv
// IR reflectance sensor time-to-decay sampler, 8 channels.
// Each frame precharges the selected pads high, releases them, and records
// the count at which each synchronized pad first reads low.
// Optional feature: define IR_TTD_FILTER_EN to average each new result with
// the previous one (two-tap running mean); undefined loads raw results.
module ir_ttd_sampler #(
    parameter int          CHARGE_CYC = 160,
    parameter logic [16:0] TIMEOUT    = 17'd100000,
    parameter int          GAP_CYC    = 1600
) (
    input  logic             WF_CLK,
    input  logic             reset,
    ir_ttd_sampler_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        CHARGE,
        MEASURE,
        UPDATE,
        GAP
    } state_t;

    localparam logic [16:0] CHG_LAST = 17'(CHARGE_CYC - 1);
    localparam logic [16:0] GAP_LAST = 17'(GAP_CYC - 1);

    state_t       state_q, state_d;
    logic [16:0]  cnt_q, cnt_d;
    logic [7:0]   sel_q, sel_d;
    logic [7:0]   cap_q, cap_d;
    logic [7:0]   sync1_q, sync2_q;
    logic [16:0]  res_q [8];
    logic [16:0]  res_d [8];
    logic [16:0]  final_v [8];
    logic [135:0] ttd_q, ttd_d;
    logic         fv_q, fv_d;
    logic         meas_done;

`ifdef IR_TTD_FILTER_EN
    // Two-tap mean; the sum is carried at 18 bits so it cannot overflow.
    function automatic logic [16:0] filt(input logic [16:0] prev, input logic [16:0] nw);
        logic [17:0] sum;
        sum = {1'b0, prev} + {1'b0, nw};
        return sum[17:1];
    endfunction
`endif

    // Two-flop synchronizer on the asynchronous pad inputs.
    always_ff @(posedge WF_CLK or posedge reset) begin
        if (reset) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= bus.sense_in;
            sync2_q <= sync1_q;
        end
    end

    // Control state: FSM, phase counter, latched select, captured flags, outputs.
    always_ff @(posedge WF_CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 8'h00;
            cap_q   <= 8'h00;
            ttd_q   <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            cap_q   <= cap_d;
            ttd_q   <= ttd_d;
            fv_q    <= fv_d;
        end
    end

    // Per-channel capture registers; only read when the matching flag is set.
    always_ff @(posedge WF_CLK) begin
        for (int i = 0; i < 8; i++) begin
            res_q[i] <= res_d[i];
        end
    end

    // Next-state and datapath. Results and frame_valid are registered on the
    // edge entering UPDATE so both are visible together during UPDATE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        cap_d     = cap_q;
        res_d     = res_q;
        ttd_d     = ttd_q;
        fv_d      = 1'b0;
        meas_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            final_v[i] = '0;
        end

        case (state_q)
            IDLE: begin
                state_d = CHARGE;
                cnt_d   = '0;
                sel_d   = bus.channel_sel;
            end
            CHARGE: begin
                if (cnt_q == CHG_LAST) begin
                    state_d = MEASURE;
                    cnt_d   = 17'd1;
                    cap_d   = 8'h00;
                end else begin
                    cnt_d = cnt_q + 17'd1;
                end
            end
            MEASURE: begin
                for (int i = 0; i < 8; i++) begin
                    if (sel_q[i] && !cap_q[i] && !sync2_q[i]) begin
                        cap_d[i] = 1'b1;
                        res_d[i] = cnt_q;
                    end
                end
                meas_done = ((cap_d | ~sel_q) == 8'hFF) || (cnt_q == TIMEOUT);
                if (meas_done) begin
                    state_d = UPDATE;
                    cnt_d   = '0;
                    fv_d    = 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        if (!sel_q[i]) begin
                            final_v[i] = '0;
                        end else if (cap_d[i]) begin
                            final_v[i] = res_d[i];
                        end else begin
                            final_v[i] = TIMEOUT;
                        end
`ifdef IR_TTD_FILTER_EN
                        ttd_d[17*i +: 17] = sel_q[i] ? filt(ttd_q[17*i +: 17], final_v[i]) : 17'd0;
`else
                        ttd_d[17*i +: 17] = final_v[i];
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 17'd1;
                end
            end
            UPDATE: begin
                state_d = GAP;
                cnt_d   = '0;
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = CHARGE;
                    cnt_d   = '0;
                    sel_d   = bus.channel_sel;
                end else begin
                    cnt_d = cnt_q + 17'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.sense_oe    = (state_q == CHARGE) ? sel_q : 8'h00;
    assign bus.ir_evenLED  = ((state_q == CHARGE) || (state_q == MEASURE)) && (|(sel_q & 8'h55));
    assign bus.ir_oddLED   = ((state_q == CHARGE) || (state_q == MEASURE)) && (|(sel_q & 8'hAA));
    assign bus.ttd_flat    = ttd_q;
    assign bus.frame_valid = fv_q;

endmodule

// File: tb/tb_ir_ttd_sampler.sv
// Bench for ir_ttd_sampler: directed frames plus randomized decay times,
// checked against a frame-level model of expected decay counts.
module tb_ir_ttd_sampler;
    localparam int          C     = 12;
    localparam logic [16:0] T     = 17'd600;
    localparam int          G     = 24;
    localparam int          NEVER = 32'h7fff_ffff;

    logic WF_CLK = 1'b0;
    logic reset  = 1'b1;

    ir_ttd_sampler_if bus();

    ir_ttd_sampler #(.CHARGE_CYC(C), .TIMEOUT(T), .GAP_CYC(G)) dut (
        .WF_CLK (WF_CLK),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 WF_CLK = ~WF_CLK;

    int          total = 0;
    int          bad   = 0;
    int          fall_at   [8];
    int          glitch_at [8];
    logic [16:0] prev_out  [8];

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge WF_CLK);
    endtask

    task automatic set_pads(input int fall, input int glitch);
        for (int i = 0; i < 8; i++) begin
            fall_at[i]   = fall;
            glitch_at[i] = glitch;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_ttd", bus.ttd_flat, 136'd0);
        chk("rst_fv", 136'(bus.frame_valid), 136'd0);
        chk("rst_oe_led", 136'({bus.sense_oe, bus.ir_evenLED, bus.ir_oddLED}), 136'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_hold_fv", 136'(bus.frame_valid), 136'd0);
        end
        reset = 1'b0;
        bus.sense_in = 8'hFF;
        for (int i = 0; i < 8; i++) prev_out[i] = '0;
    endtask

    // Caller is at a negedge where the next rising edge enters CHARGE.
    task automatic run_frame(input logic [7:0] sel, input int rst_at);
        logic [16:0]  e [8];
        logic [16:0]  o;
        logic [135:0] exp_flat;
        int           len, c, first_low;
        bit           seen;

        len = 0;
        for (int i = 0; i < 8; i++) begin
            first_low = (glitch_at[i] > 0) ? glitch_at[i] : fall_at[i];
            if (!sel[i])                       e[i] = '0;
            else if (first_low < 0)            e[i] = 17'd1;
            else if (first_low >= int'(T) - 2) e[i] = T;
            else                               e[i] = 17'(first_low + 2);
            if (sel[i] && int'(e[i]) > len) len = int'(e[i]);
        end
        if (sel == 8'h00) len = 1;
        for (int i = 0; i < 8; i++) begin
`ifdef IR_TTD_FILTER_EN
            o = sel[i] ? 17'((18'(prev_out[i]) + 18'(e[i])) >> 1) : 17'd0;
`else
            o = e[i];
`endif
            exp_flat[17*i +: 17] = o;
        end

        bus.channel_sel = sel;
        for (int i = 0; i < 8; i++) bus.sense_in[i] = (fall_at[i] < 0) ? 1'b0 : 1'b1;
        tick();
        chk("charge_oe", 136'(bus.sense_oe), 136'(sel));
        chk("charge_led", 136'({bus.ir_evenLED, bus.ir_oddLED}),
            136'({|(sel & 8'h55), |(sel & 8'hAA)}));
        repeat (C - 1) tick();

        c = 0;
        seen = 1'b0;
        while (!seen && c <= int'(T) + 4) begin
            tick();
            c++;
            if (bus.frame_valid) begin
                seen = 1'b1;
            end else begin
                if (c == 1) begin
                    chk("meas_oe", 136'(bus.sense_oe), 136'd0);
                    chk("meas_led", 136'({bus.ir_evenLED, bus.ir_oddLED}),
                        136'({|(sel & 8'h55), |(sel & 8'hAA)}));
                end
                if (c == 5) bus.channel_sel = 8'($urandom);
                if (c == rst_at) begin
                    do_reset();
                    return;
                end
                for (int i = 0; i < 8; i++) begin
                    if (glitch_at[i] > 0 && c == glitch_at[i]) bus.sense_in[i] = 1'b0;
                    else if (fall_at[i] < 0)                   bus.sense_in[i] = 1'b0;
                    else                                       bus.sense_in[i] = (c >= fall_at[i]) ? 1'b0 : 1'b1;
                end
            end
        end
        if (!seen) chk("fv_timeout", 136'd0, 136'd1);
        chk("meas_len", 136'(c - 1), 136'(len));
        chk("ttd_flat", bus.ttd_flat, exp_flat);
        for (int i = 0; i < 8; i++) prev_out[i] = exp_flat[17*i +: 17];

        bus.sense_in = 8'hFF;
        tick();
        chk("fv_pulse_end", 136'(bus.frame_valid), 136'd0);
        chk("gap_oe_led", 136'({bus.sense_oe, bus.ir_evenLED, bus.ir_oddLED}), 136'd0);
        repeat (G - 1) tick();
    endtask

    initial begin
        logic [7:0] rsel;
        bus.channel_sel = 8'h00;
        bus.sense_in    = 8'hFF;
        for (int i = 0; i < 8; i++) prev_out[i] = '0;
        repeat (3) tick();
        chk("reset_ttd", bus.ttd_flat, 136'd0);
        chk("reset_fv", 136'(bus.frame_valid), 136'd0);
        chk("reset_oe_led", 136'({bus.sense_oe, bus.ir_evenLED, bus.ir_oddLED}), 136'd0);
        reset = 1'b0;

        // all channels decay together
        set_pads(500, 0);
        run_frame(8'hFF, 0);
        // single even channel that never decays
        set_pads(NEVER, 0);
        run_frame(8'h01, 0);
        // nothing selected
        set_pads(10, 0);
        run_frame(8'h00, 0);
        // one-clock glitch, later real fall ignored
        set_pads(NEVER, 0);
        glitch_at[3] = 200;
        fall_at[3]   = 900;
        run_frame(8'h08, 0);
        // pad already low at release, plus an odd channel
        set_pads(NEVER, 0);
        fall_at[2] = -1;
        fall_at[5] = 30;
        run_frame(8'h24, 0);
        // reset in the middle of MEASURE, then a normal frame
        set_pads(500, 0);
        run_frame(8'hFF, 50);
        set_pads(0, 0);
        for (int i = 0; i < 8; i++) fall_at[i] = 40 + 17 * i;
        run_frame(8'hA5, 0);

        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 8; i++) begin
                glitch_at[i] = 0;
                if ($urandom_range(0, 9) == 0)      fall_at[i] = -1;
                else if ($urandom_range(0, 9) == 0) fall_at[i] = NEVER;
                else                                fall_at[i] = int'($urandom_range(1, 700));
            end
            rsel = 8'($urandom);
            run_frame(rsel, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
